// File: rtl/cbp_subtractor_pipe.sv
// cbp_subtractor_pipe: pipelined A - B - Bin built from carry-bypass blocks.
// The subtraction is done as A + ~B + ~Bin; each W-bit bypass block is one
// pipeline stage, so the pipeline is skewed: stage k adds its diff slice to the
// lower slices produced by earlier stages and forwards the unprocessed upper
// operand slices.
// Optional build macro: CBP_SUB_SATURATE_EN clamps Diff to the signed limits
// whenever Ovf is set. When it is not defined, Diff wraps mod 2^NUM_BITS.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. All stages advance together when the output register is empty or being
// consumed (advance = !out_valid || out_ready). in_ready equals advance, so the
// operands are captured only on an edge where in_valid && in_ready. Bubbles are
// kept, not compressed.
module cbp_subtractor_pipe #(
    parameter int NUM_BITS   = 32,
    parameter int NUM_STAGES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] A,
    input  logic [NUM_BITS-1:0] B,
    input  logic                Bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] Diff,
    output logic                Bout,
    output logic                Ovf,
    output logic                busy
);

    localparam int W    = NUM_BITS / NUM_STAGES;
    localparam int LAST = NUM_STAGES - 1;

    logic                  w_advance;
    logic [NUM_STAGES-1:0] w_stage_valid;
    logic [NUM_BITS-1:0]   w_diff_raw;
    logic                  w_amsb;
    logic                  w_bmsb;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            localparam int DW = (k + 1) * W;
            localparam int RW = NUM_BITS - (k + 1) * W;

            logic          w_vin;
            logic          w_cin;
            logic          w_amsb_in;
            logic          w_bmsb_in;
            logic [W-1:0]  w_a;
            logic [W-1:0]  w_b;
            logic [W-1:0]  w_sum;
            logic          w_ripple_cout;
            logic          w_bypass;
            logic          w_cout;
            logic [DW-1:0] w_diff_next;

            logic          r_valid;
            logic          r_carry;
            logic          r_amsb;
            logic          r_bmsb;
            logic [DW-1:0] r_diff;

            if (k == 0) begin : g_src
                assign w_vin       = in_valid;
                assign w_cin       = ~Bin;
                assign w_a         = A[W-1:0];
                assign w_b         = B[W-1:0];
                assign w_amsb_in   = A[NUM_BITS-1];
                assign w_bmsb_in   = B[NUM_BITS-1];
                assign w_diff_next = w_sum;
            end else begin : g_src
                assign w_vin       = g_stage[k-1].r_valid;
                assign w_cin       = g_stage[k-1].r_carry;
                assign w_a         = g_stage[k-1].g_rem.r_arem[W-1:0];
                assign w_b         = g_stage[k-1].g_rem.r_brem[W-1:0];
                assign w_amsb_in   = g_stage[k-1].r_amsb;
                assign w_bmsb_in   = g_stage[k-1].r_bmsb;
                assign w_diff_next = {w_sum, g_stage[k-1].r_diff};
            end

            // Ripple add of A + ~B inside the block, carry starting at w_cin.
            always_comb begin : ripple
                logic c;
                c     = w_cin;
                w_sum = '0;
                for (int i = 0; i < W; i++) begin
                    w_sum[i] = w_a[i] ^ ~w_b[i] ^ c;
                    c        = (w_a[i] & ~w_b[i]) | (c & ~(w_a[i] ^ w_b[i]));
                end
                w_ripple_cout = c;
            end

            // When every bit propagates, the incoming carry skips the block.
            assign w_bypass = &(~(w_a ^ w_b));
            assign w_cout   = w_bypass ? w_cin : w_ripple_cout;

            assign w_stage_valid[k] = r_valid;

            // Stage register; carry resets to 1 so a cleared pipe shows no borrow.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b1;
                    r_amsb  <= 1'b0;
                    r_bmsb  <= 1'b0;
                    r_diff  <= '0;
                end else if (w_advance) begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_carry <= w_cout;
                        r_amsb  <= w_amsb_in;
                        r_bmsb  <= w_bmsb_in;
                        r_diff  <= w_diff_next;
                    end
                end
            end

            if (k < LAST) begin : g_rem
                logic [RW-1:0] r_arem;
                logic [RW-1:0] r_brem;
                logic [RW-1:0] w_arem_in;
                logic [RW-1:0] w_brem_in;

                if (k == 0) begin : g_src
                    assign w_arem_in = A[NUM_BITS-1:W];
                    assign w_brem_in = B[NUM_BITS-1:W];
                end else begin : g_src
                    assign w_arem_in = g_stage[k-1].g_rem.r_arem[RW+W-1:W];
                    assign w_brem_in = g_stage[k-1].g_rem.r_brem[RW+W-1:W];
                end

                // Carry the not-yet-processed operand slices down the pipe.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_arem <= '0;
                        r_brem <= '0;
                    end else if (w_advance && w_vin) begin
                        r_arem <= w_arem_in;
                        r_brem <= w_brem_in;
                    end
                end
            end
        end
    endgenerate

    assign out_valid  = g_stage[LAST].r_valid;
    assign w_advance  = !out_valid || out_ready;
    assign in_ready   = w_advance;
    assign busy       = |w_stage_valid;
    assign w_diff_raw = g_stage[LAST].r_diff;
    assign w_amsb     = g_stage[LAST].r_amsb;
    assign w_bmsb     = g_stage[LAST].r_bmsb;
    assign Bout       = ~g_stage[LAST].r_carry;
    assign Ovf        = (w_amsb != w_bmsb) && (w_diff_raw[NUM_BITS-1] != w_amsb);

`ifdef CBP_SUB_SATURATE_EN
    // Clamp to the signed limit on the side the minuend sits on.
    always_comb begin
        Diff = w_diff_raw;
        if (Ovf) begin
            Diff = w_amsb ? {1'b1, {(NUM_BITS-1){1'b0}}} : {1'b0, {(NUM_BITS-1){1'b1}}};
        end
    end
`else
    // Wrapping result straight from the last stage.
    always_comb begin
        Diff = w_diff_raw;
    end
`endif

endmodule

// File: tb/tb_cbp_subtractor_pipe.sv
// tb_cbp_subtractor_pipe: directed and randomized checks of the pipelined
// subtractor against an arithmetic reference model and an expected queue.
module tb_cbp_subtractor_pipe;

    localparam int NB = 32;
    localparam int NS = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NB-1:0] a_in;
    logic [NB-1:0] b_in;
    logic          bin_in;
    logic          out_valid;
    logic          out_ready;
    logic [NB-1:0] diff;
    logic          bout;
    logic          ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic [NB+1:0] exp_q[$];
    logic rand_on;

    cbp_subtractor_pipe #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .Bin(bin_in), .out_valid(out_valid),
        .out_ready(out_ready), .Diff(diff), .Bout(bout), .Ovf(ovf), .busy(busy)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic, result packed as {ovf, bout, diff}.
    function automatic logic [NB+1:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                            input logic bin);
        longint ua, ub, sa, sb, ud, sd;
        logic [63:0] udv;
        logic [NB-1:0] d;
        logic bo, ov;
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ud  = ua - ub - longint'({63'b0, bin});
        sd  = sa - sb - longint'({63'b0, bin});
        bo  = (ud < 0);
        ov  = (sd > SMAX) || (sd < SMIN);
        udv = ud;
        d   = udv[NB-1:0];
`ifdef CBP_SUB_SATURATE_EN
        if (ov) d = (sd < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, bo, d};
    endfunction

    function automatic logic [NB-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, expv);
        end
    endtask

    // Drive one operation and wait (bounded) for it to be accepted.
    task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic bin,
                        input logic [NB+1:0] e);
        int n;
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        bin_in   = bin;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout observed in_ready=0 expected 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(e);
        end
    endtask

    // Called just after the accept edge with in_valid already low.
    task automatic lat_check();
        chk("lat_edge0", 64'(out_valid), 64'(0));
        for (int i = 1; i < NS; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_edge%0d", i), 64'(out_valid), 64'(i == NS - 1));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // scoreboard: every consumed result must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_result observed %0h expected none", {ovf, bout, diff});
            end else begin
                logic [NB+1:0] e;
                e = exp_q.pop_front();
                checks++;
                assert ({ovf, bout, diff} === e) else begin
                    errors++;
                    $error("FAIL result observed %0h expected %0h", {ovf, bout, diff}, e);
                end
            end
        end
    end

    initial begin
        logic [NB+1:0] e3;
        logic [NB-1:0] ra, rb;
        logic          rbin;

        // reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        bin_in    = 1'b0;
        rand_on   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_diff", 64'(diff), 64'(0));
        chk("rst_bout", 64'(bout), 64'(0));
        chk("rst_ovf", 64'(ovf), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // 1: basic subtract with latency
        send(32'd30, 32'd10, 1'b0, {1'b0, 1'b0, 32'd20});
        in_valid = 1'b0;
        lat_check();
        chk("t1_diff", 64'(diff), 64'(20));
        drain();

        // 2: borrow and signed operands
        send(32'd10, 32'd20, 1'b0, {1'b0, 1'b1, 32'hFFFF_FFF6});
        send(32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b1, {1'b0, 1'b0, 32'd9});
        in_valid = 1'b0;
        drain();

        // 3: negative overflow
`ifdef CBP_SUB_SATURATE_EN
        e3 = {1'b1, 1'b0, 32'h8000_0000};
`else
        e3 = {1'b1, 1'b0, 32'h7FFF_FFFF};
`endif
        send(32'h8000_0000, 32'd1, 1'b0, e3);
        in_valid = 1'b0;
        drain();

        // 4: full bypass chain, equal operands
        send(32'd14958, 32'd14958, 1'b1, {1'b0, 1'b1, 32'hFFFF_FFFF});
        send(32'd14958, 32'd14958, 1'b0, {1'b0, 1'b0, 32'h0});
        in_valid = 1'b0;
        drain();

        // 5: 8 back-to-back ops with a 3-cycle output stall
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra   = $urandom;
                    rb   = $urandom;
                    rbin = 1'($urandom_range(0, 1));
                    send(ra, rb, rbin, model(ra, rb, rbin));
                end
                in_valid = 1'b0;
            end
            begin
                logic [NB+2:0] held;
                int n;
                n = 0;
                @(posedge clk);
                #1;
                while (!out_valid && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                held      = {out_valid, ovf, bout, diff};
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 64'(in_ready), 64'(0));
                    chk("stall_hold", 64'({out_valid, ovf, bout, diff}), 64'(held));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // random stream with random backpressure and input bubbles
        rand_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    ra   = pick();
                    rb   = ($urandom_range(0, 4) == 0) ? ra : pick();
                    rbin = 1'($urandom_range(0, 1));
                    send(ra, rb, rbin, model(ra, rb, rbin));
                    if ($urandom_range(0, 4) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
                rand_on  = 1'b0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // 6: asynchronous reset with operations in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            send(ra, rb, 1'b0, model(ra, rb, 1'b0));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
        chk("pre_rst_busy", 64'(busy), 64'(1));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'(0));
        chk("async_rst_busy", 64'(busy), 64'(0));
        chk("async_rst_diff", 64'(diff), 64'(0));
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'({out_valid, busy}), 64'(0));
        end
        @(posedge clk);
        #1;
        ra = 32'h1234_5678;
        rb = 32'h0FED_CBA9;
        send(ra, rb, 1'b1, model(ra, rb, 1'b1));
        in_valid = 1'b0;
        lat_check();
        drain();

        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbp_subtractor_pipe.md
Name: cbp_subtractor_pipe

Overview:
Pipelined signed/unsigned subtractor computing A - B - Bin, built from the same carry-bypass block structure as the team's CarryBypassAdder but run in the borrow direction. Each bypass block occupies one pipeline stage. A valid/ready handshake with full backpressure sits on both sides. It is the inverse-arithmetic companion to the adder in the datapath and feeds compare/decrement paths that need borrow and signed overflow.

Parameters:
NUM_BITS, 32, operand and result width; must be a multiple of NUM_STAGES.
NUM_STAGES, 4, number of bypass blocks, which equals the number of pipeline register stages; block width W = NUM_BITS/NUM_STAGES.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands this cycle.
A  input  NUM_BITS  minuend.
B  input  NUM_BITS  subtrahend.
Bin  input  1  borrow in.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
Diff  output  NUM_BITS  A - B - Bin, mod 2^NUM_BITS.
Bout  output  1  unsigned borrow out.
Ovf  output  1  signed overflow.
busy  output  1  any stage holds a valid operation.

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits clear.
  - out_valid=0, busy=0, Diff=0, Bout=0, Ovf=0.
  - in_ready=1 once rst_n is high.
  - Operations in flight are discarded and never emitted.
- Arithmetic: computed as A + ~B + ~Bin.
  - Bout = NOT(final carry), i.e. 1 iff unsigned A < B + Bin.
  - Ovf = (A[MSB] != B[MSB]) AND (Diff[MSB] != A[MSB]).
- Stage k handles bits [k*W +: W].
  - Per-bit propagate p_i = ~(A_i ^ B_i).
  - Block borrow-out = incoming borrow when all p_i=1 (bypass mux); otherwise the block's ripple result.
- Each stage registers:
  - its W diff bits and the inter-block carry;
  - still-unprocessed upper slices of A and B;
  - the MSB bits A[MSB] and B[MSB] needed for Ovf.
  - Lower diff slices are carried forward; this is a skewed pipeline.
- Handshake: advance = !out_valid || out_ready.
  - All stages shift together when advance=1 and hold when advance=0.
  - in_ready = advance.
  - An input is accepted on an edge where in_valid && in_ready.
  - Result is consumed on an edge where out_valid && out_ready.
  - Bubbles are not compressed.
- Latency: an operation accepted on edge t is presented on out_valid after edge t+NUM_STAGES-1 when there is no stall.
  - Throughput is 1 op/cycle.
- While stalled, out_valid, Diff, Bout and Ovf stay stable.
  - In-flight ops are neither lost nor reordered.
- Simultaneous accept and consume on the same edge is legal and keeps full throughput.
- If in_valid=1 and in_ready=0, the operands are not captured; the source must hold them.
- busy = OR of all stage valid bits.
- Operands are treated as bit vectors; signed or unsigned interpretation is up to the user via Bout/Ovf.

Optional Feature:
CBP_SUB_SATURATE_EN
- Defined: when Ovf=1, Diff is clamped to signed limits.
  - Negative overflow (A[MSB]=1) gives 100..0.
  - Positive overflow gives 011..1.
  - Ovf still reports 1; Bout is unchanged.
- Undefined: Diff wraps mod 2^NUM_BITS. The clamp logic is not synthesized.

Test Plan:
1. A=30, B=10, Bin=0, out_ready=1 -> out_valid after 4th edge counting the accept edge; Diff=20, Bout=0, Ovf=0.
2. A=10, B=20, Bin=0 -> Diff=0xFFFFFFF6, Bout=1, Ovf=0. Then A=-10 (0xFFFFFFF6), B=-20, Bin=1 -> Diff=9, Bout=0, Ovf=0.
3. A=0x80000000, B=1, Bin=0 -> Ovf=1, Bout=0.
   - Without macro: Diff=0x7FFFFFFF.
   - With CBP_SUB_SATURATE_EN: Diff=0x80000000.
4. A=14958, B=14958, Bin=1 -> Diff=0xFFFFFFFF, Bout=1 via the full bypass chain through all 4 blocks. Same operands with Bin=0 -> Diff=0, Bout=0.
5. Stream 8 back-to-back ops; drop out_ready for 3 cycles once out_valid=1.
   - in_ready=0 and outputs stable while stalled.
   - All 8 results emerge in order, none duplicated or lost.
6. Accept 3 ops, pull rst_n low mid-cycle -> out_valid=0 and busy=0 immediately (asynchronously). After release, nothing is emitted until new input, and a new op returns the correct result with 4-cycle latency.
